// File: rtl/freq_sweep_scheduler.sv
// freq_sweep_scheduler: steps the NCO frequency_factor from a start value to a stop value.
//   It dwells a programmable number of phase wraps at each step.
//   Sweeps are single-shot or continuous, and can be paused or aborted.
// Latency: frequency_factor, step_strobe and done are registered. They change one cycle after
//   the wrap or abort that triggers them.
// Ports: clk, rst_n (async, active-low); start/abort/pause control;
//   mode_cont/dir_up/start_factor/stop_factor/dwell_cycles configuration (latched on start);
//   phase_in from the accumulator; frequency_factor to the accumulator;
//   busy/step_strobe/done status.
// Optional: define SWEEP_PINGPONG_EN to make continuous sweeps bounce between the endpoints.
//   Without it, continuous sweeps reload the start factor.
module freq_sweep_scheduler #(
    parameter int unsigned DWELL_W     = 8,
    parameter logic [3:0]  IDLE_FACTOR = 4'd1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               pause,
    input  logic               mode_cont,
    input  logic               dir_up,
    input  logic [3:0]         start_factor,
    input  logic [3:0]         stop_factor,
    input  logic [DWELL_W-1:0] dwell_cycles,
    input  logic [7:0]         phase_in,
    output logic [3:0]         frequency_factor,
    output logic               busy,
    output logic               step_strobe,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, DWELL, PAUSED} state_t;

    localparam logic [DWELL_W-1:0] DW_ONE = DWELL_W'(1);

    state_t             state_q, state_d;
    logic [3:0]         factor_q, factor_d;
    logic [3:0]         start_q, start_d;
    logic [3:0]         stop_q, stop_d;
    logic               cont_q, cont_d;
    logic               dir_q, dir_d;
    logic               busy_q, busy_d;
    logic               strobe_q, strobe_d;
    logic               done_q, done_d;
    logic [DWELL_W-1:0] count_q, count_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [7:0]         phase_prev_q;

    logic               wrap;
    logic               final_wrap;
    logic               at_end;
    logic [3:0]         target;
    logic [3:0]         step_f;

`ifdef SWEEP_PINGPONG_EN
    // High while the sweep heads back toward start_q after bouncing off stop_q.
    logic               back_q, back_d;
    assign target = back_q ? start_q : stop_q;
`else
    assign target = stop_q;
`endif

    // The accumulator always advances, so a drop in phase means it wrapped.
    assign wrap       = (phase_in < phase_prev_q);
    assign final_wrap = wrap && (count_q == dwell_q - DW_ONE);
    // The end test also catches a start factor that is already past the target.
    // This stops 15->0 or 0->15 from ever being taken as a step.
    assign at_end     = dir_q ? (factor_q >= target) : (factor_q <= target);
    assign step_f     = dir_q ? (factor_q + 4'd1) : (factor_q - 4'd1);

    always_comb begin
        state_d  = state_q;
        factor_d = factor_q;
        start_d  = start_q;
        stop_d   = stop_q;
        cont_d   = cont_q;
        dir_d    = dir_q;
        busy_d   = busy_q;
        count_d  = count_q;
        dwell_d  = dwell_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;
`ifdef SWEEP_PINGPONG_EN
        back_d   = back_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    start_d  = start_factor;
                    stop_d   = stop_factor;
                    cont_d   = mode_cont;
                    dir_d    = dir_up;
                    dwell_d  = (dwell_cycles == '0) ? DW_ONE : dwell_cycles;
                    factor_d = start_factor;
                    count_d  = '0;
                    busy_d   = 1'b1;
                    state_d  = DWELL;
`ifdef SWEEP_PINGPONG_EN
                    back_d   = 1'b0;
`endif
                end
            end
            DWELL, PAUSED: begin
                if (abort) begin
                    factor_d = IDLE_FACTOR;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    count_d  = '0;
                    state_d  = IDLE;
                end else if (state_q == PAUSED) begin
                    if (!pause) begin
                        state_d = DWELL;
                    end
                end else if (final_wrap) begin
                    // The step is taken even if pause is high.
                    // PAUSED is entered on a later cycle.
                    count_d = '0;
                    if (at_end && !cont_q) begin
                        factor_d = IDLE_FACTOR;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        state_d  = IDLE;
                    end else if (at_end) begin
                        strobe_d = 1'b1;
                        factor_d = start_q;
`ifdef SWEEP_PINGPONG_EN
                        // Bounce only off a real endpoint of a multi-factor sweep.
                        // Otherwise fall back to reloading the start factor.
                        if (factor_q == target && start_q != stop_q) begin
                            dir_d    = ~dir_q;
                            back_d   = ~back_q;
                            factor_d = dir_q ? (factor_q - 4'd1) : (factor_q + 4'd1);
                        end
`endif
                    end else begin
                        strobe_d = 1'b1;
                        factor_d = step_f;
                    end
                end else begin
                    if (wrap) begin
                        count_d = count_q + DW_ONE;
                    end
                    if (pause) begin
                        state_d = PAUSED;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            factor_q     <= IDLE_FACTOR;
            start_q      <= '0;
            stop_q       <= '0;
            cont_q       <= 1'b0;
            dir_q        <= 1'b0;
            busy_q       <= 1'b0;
            strobe_q     <= 1'b0;
            done_q       <= 1'b0;
            count_q      <= '0;
            dwell_q      <= DW_ONE;
            phase_prev_q <= '0;
`ifdef SWEEP_PINGPONG_EN
            back_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            factor_q     <= factor_d;
            start_q      <= start_d;
            stop_q       <= stop_d;
            cont_q       <= cont_d;
            dir_q        <= dir_d;
            busy_q       <= busy_d;
            strobe_q     <= strobe_d;
            done_q       <= done_d;
            count_q      <= count_d;
            dwell_q      <= dwell_d;
            phase_prev_q <= phase_in;
`ifdef SWEEP_PINGPONG_EN
            back_q       <= back_d;
`endif
        end
    end

    assign frequency_factor = factor_q;
    assign busy             = busy_q;
    assign step_strobe      = strobe_q;
    assign done             = done_q;

endmodule

// File: tb/tb_freq_sweep_scheduler.sv
module tb_freq_sweep_scheduler;

    localparam logic [3:0] IDLE_F = 4'd1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       pause = 1'b0;
    logic       mode_cont = 1'b0;
    logic       dir_up = 1'b1;
    logic [3:0] start_factor = 4'd0;
    logic [3:0] stop_factor = 4'd0;
    logic [7:0] dwell_cycles = 8'd0;
    logic [7:0] phase_in;
    logic [3:0] frequency_factor;
    logic       busy;
    logic       step_strobe;
    logic       done;

    int checks = 0;
    int errors = 0;

    freq_sweep_scheduler #(.DWELL_W(8), .IDLE_FACTOR(IDLE_F)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pause(pause),
        .mode_cont(mode_cont), .dir_up(dir_up), .start_factor(start_factor),
        .stop_factor(stop_factor), .dwell_cycles(dwell_cycles), .phase_in(phase_in),
        .frequency_factor(frequency_factor), .busy(busy), .step_strobe(step_strobe),
        .done(done)
    );

    always #5 clk = ~clk;

    // Phase accumulator: advances by (factor+1)*13 per clock.
    // A carry out of bit 7 is one waveform period.
    logic [7:0] acc = 8'd0;
    logic       carry_q = 1'b0;
    logic [8:0] acc_sum;
    assign acc_sum  = {1'b0, acc} + 9'(({5'd0, frequency_factor} + 9'd1) * 9'd13);
    assign phase_in = acc;
    always @(posedge clk) begin
        acc     <= acc_sum[7:0];
        carry_q <= acc_sum[8];
    end

    // Observer, sampled 2ns after each rising edge.
    // Each strobe (or busy rising) opens a new factor segment.
    // A carry from the edge just taken is credited to the factor now shown.
    // The DUT acts on that carry at the next edge with this factor.
    int   seg_f[$];
    int   seg_w[$];
    int   n_strobe = 0;
    int   n_done = 0;
    int   n_viol = 0;
    logic busy_prev = 1'b0;
    logic [3:0] last_f = 4'd0;
    always @(posedge clk) begin
        #2;
        if (busy && (!busy_prev || step_strobe)) begin
            seg_f.push_back(int'(frequency_factor));
            seg_w.push_back(0);
        end else if (busy && busy_prev && frequency_factor != last_f) begin
            n_viol++;
        end
        if (busy && carry_q && !pause && seg_w.size() > 0) seg_w[seg_w.size()-1] += 1;
        if (step_strobe) n_strobe++;
        if (done) n_done++;
        if (step_strobe && done) n_viol++;
        if (step_strobe && !busy) n_viol++;
        busy_prev = busy;
        last_f    = frequency_factor;
    end

    // Reference: the factor sequence a sweep should visit, from the endpoints alone.
    int exp_q[$];
    task automatic build_expected(input int s, input int e, input bit up, input bit cont, input int n);
        int pass_q[$];
        int per_q[$];
        int span;
        span = up ? e - s : s - e;
        if (span < 0) span = 0;
        for (int i = 0; i <= span; i++) pass_q.push_back(up ? s + i : s - i);
        per_q = pass_q;
`ifdef SWEEP_PINGPONG_EN
        if (cont) for (int i = pass_q.size() - 2; i >= 1; i--) per_q.push_back(pass_q[i]);
`endif
        exp_q.delete();
        if (!cont) exp_q = pass_q;
        else for (int i = 0; i < n; i++) exp_q.push_back(per_q[i % per_q.size()]);
    endtask

    task automatic clear_obs();
        seg_f.delete();
        seg_w.delete();
        n_strobe = 0;
        n_done   = 0;
        n_viol   = 0;
    endtask

    task automatic run_sweep(input string name, input int s, input int e, input bit up,
                             input bit cont, input int dwell, input int nseg,
                             input int pause_wraps, input bit poke_start);
        int deff, cyc, bad, first_bad, pw, strobes_before, nlim;
        bit paused_done, abort_sent;
        logic [3:0] f_before;
        deff = (dwell == 0) ? 1 : dwell;
        paused_done = 0;
        abort_sent  = 0;
        @(negedge clk);
        clear_obs();
        start_factor = 4'(s);
        stop_factor  = 4'(e);
        dir_up       = up;
        mode_cont    = cont;
        dwell_cycles = 8'(dwell);
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_start: got %b want 1", name, busy);
        end
        // Configuration is latched; these changes must not disturb the sweep.
        start_factor = 4'($urandom_range(15, 0));
        stop_factor  = 4'($urandom_range(15, 0));
        dir_up       = 1'($urandom_range(1, 0));
        mode_cont    = 1'($urandom_range(1, 0));
        dwell_cycles = 8'($urandom_range(9, 0));
        cyc = 0;
        while (cyc < 8000) begin
            @(negedge clk);
            cyc++;
            start = (poke_start && cyc == 5);
            abort = 1'b0;
            if (!busy) break;
            if (pause_wraps > 0 && !paused_done && seg_f.size() == 2) begin
                pause = 1'b1;
                f_before = frequency_factor;
                strobes_before = n_strobe;
                pw = 0;
                while (pw < pause_wraps && cyc < 8000) begin
                    @(negedge clk);
                    cyc++;
                    if (carry_q) pw++;
                end
                checks++;
                if (n_strobe !== strobes_before || frequency_factor !== f_before) begin
                    errors++;
                    $display("FAIL %s pause_hold: strobes %0d factor %0d, want strobes %0d factor %0d",
                             name, n_strobe, frequency_factor, strobes_before, f_before);
                end
                pause = 1'b0;
                paused_done = 1;
            end
            if (cont && !abort_sent && seg_f.size() > nseg) begin
                abort = 1'b1;
                abort_sent = 1;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (cyc >= 8000) begin
            errors++;
            $display("FAIL %s timeout: sweep still busy after %0d cycles", name, cyc);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || frequency_factor !== IDLE_F) begin
            errors++;
            $display("FAIL %s end_state: busy %b factor %0d, want busy 0 factor %0d",
                     name, busy, frequency_factor, IDLE_F);
        end
        checks++;
        if (n_done !== 1) begin
            errors++;
            $display("FAIL %s done_count: got %0d want 1", name, n_done);
        end
        build_expected(s, e, up, cont, seg_f.size());
        nlim = cont ? nseg + 1 : exp_q.size();
        checks++;
        if (cont ? (seg_f.size() < nlim) : (seg_f.size() != nlim)) begin
            errors++;
            $display("FAIL %s seg_count: got %0d want %0d", name, seg_f.size(), nlim);
        end
        bad = 0;
        first_bad = -1;
        for (int i = 0; i < seg_f.size() && i < exp_q.size(); i++)
            if (seg_f[i] != exp_q[i]) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s factor_seq: step %0d got %0d want %0d", name, first_bad,
                     seg_f[first_bad], exp_q[first_bad]);
        end
        bad = 0;
        for (int i = 0; i < seg_w.size() - (cont ? 1 : 0); i++)
            if (seg_w[i] != deff) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s dwell_wraps: %0d steps off, want %0d wraps each", name, bad, deff);
        end
        checks++;
        if (seg_f.size() == 0 || n_strobe != seg_f.size() - 1) begin
            errors++;
            $display("FAIL %s strobe_count: got %0d want %0d", name, n_strobe, seg_f.size() - 1);
        end
        checks++;
        if (n_viol != 0) begin
            errors++;
            $display("FAIL %s protocol: %0d violations, want 0", name, n_viol);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (frequency_factor !== IDLE_F) begin
            errors++;
            $display("FAIL reset factor: got %0d want %0d", frequency_factor, IDLE_F);
        end
        checks++;
        if (busy !== 1'b0 || step_strobe !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset flags: busy %b strobe %b done %b, want 0 0 0", busy, step_strobe, done);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_abort();
        int cyc;
        // Abort together with start in IDLE: start is dropped and no done pulse is issued.
        @(negedge clk);
        clear_obs();
        start_factor = 4'd6;
        stop_factor  = 4'd9;
        dir_up       = 1'b1;
        mode_cont    = 1'b0;
        dwell_cycles = 8'd1;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || n_done !== 0) begin
            errors++;
            $display("FAIL abort_start busy %b dones %0d, want 0 0", busy, n_done);
        end
        // Abort landing on the same edge as a final wrap (dwell 1: every wrap is final).
        clear_obs();
        stop_factor = 4'd13;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (cyc < 4000 && !(carry_q && busy && seg_f.size() >= 3)) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc >= 4000) begin
            errors++;
            $display("FAIL abort_final timeout: no wrap after %0d cycles", cyc);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (frequency_factor !== IDLE_F || done !== 1'b1 || step_strobe !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_final: factor %0d done %b strobe %b busy %b, want %0d 1 0 0",
                     frequency_factor, done, step_strobe, busy, IDLE_F);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (n_done !== 1) begin
            errors++;
            $display("FAIL abort_final done_count: got %0d want 1", n_done);
        end
    endtask

    task automatic test_midsweep_reset();
        int cyc;
        @(negedge clk);
        clear_obs();
        start_factor = 4'd0;
        stop_factor  = 4'd15;
        dir_up       = 1'b1;
        mode_cont    = 1'b1;
        dwell_cycles = 8'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (cyc < 4000 && seg_f.size() < 3) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc >= 4000) begin
            errors++;
            $display("FAIL midreset timeout: sweep never reached step 3");
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (frequency_factor !== IDLE_F || busy !== 1'b0 || step_strobe !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midreset outputs: factor %0d busy %b strobe %b done %b, want %0d 0 0 0",
                     frequency_factor, busy, step_strobe, done, IDLE_F);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_sweep("after_reset", 5, 8, 1'b1, 1'b0, 2, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        int s, e, d, n;
        bit up, cont;
        for (int it = 0; it < 12; it++) begin
            s    = $urandom_range(15, 0);
            e    = $urandom_range(15, 0);
            up   = 1'($urandom_range(1, 0));
            cont = ($urandom_range(2, 0) == 0);
            d    = $urandom_range(3, 0);
            n    = $urandom_range(7, 3);
            run_sweep("random", s, e, up, cont, d, n, 0, 1'($urandom_range(1, 0)));
        end
    endtask

    initial begin
        test_reset();
        run_sweep("single_up", 2, 5, 1'b1, 1'b0, 3, 0, 0, 1'b1);
        run_sweep("down_dwell0", 3, 1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        run_sweep("edge_15", 15, 15, 1'b1, 1'b0, 2, 0, 0, 1'b0);
        run_sweep("edge_past", 4, 2, 1'b1, 1'b0, 1, 0, 0, 1'b0);
        run_sweep("edge_0_down", 0, 3, 1'b0, 1'b0, 1, 0, 0, 1'b0);
        run_sweep("continuous", 1, 3, 1'b1, 1'b1, 1, 9, 0, 1'b0);
        run_sweep("pause", 2, 4, 1'b1, 1'b0, 4, 0, 20, 1'b0);
        test_abort();
        test_midsweep_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/freq_sweep_scheduler.md
Name: freq_sweep_scheduler

Overview:
- Sequences the 4-bit frequency_factor input of the NCO phase accumulator to produce automatic frequency sweeps for the oscilloscope test-waveform path.
- Steps the factor from a start value to a stop value, dwelling a programmable number of phase wraps (waveform periods) at each step.
- Watches the accumulator's phase output to detect wraps; supports single-shot or continuous sweeps, pause and abort.

Parameters:
- DWELL_W, 8, width of dwell_cycles (phase wraps per step).
- IDLE_FACTOR, 4'd1, frequency_factor driven while idle, after abort and after a single sweep completes.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle request; begins a sweep when idle.
- abort  in  1  terminate sweep immediately.
- pause  in  1  level; freezes dwell counting while high.
- mode_cont  in  1  1 = continuous sweep, 0 = single-shot.
- dir_up  in  1  1 = increment factor per step, 0 = decrement.
- start_factor  in  4  first factor of the sweep.
- stop_factor  in  4  last factor of the sweep.
- dwell_cycles  in  DWELL_W  phase wraps per step; 0 is treated as 1.
- phase_in  in  8  accumulator phase output.
- frequency_factor  out  4  to the accumulator.
- busy  out  1  high from the cycle after an accepted start until the sweep ends.
- step_strobe  out  1  one-cycle pulse on each factor change within a sweep, including a continuous reload.
- done  out  1  one-cycle pulse when a single-shot sweep completes or an abort takes effect.

Behaviour:
- Reset values:
  - frequency_factor = IDLE_FACTOR; busy, step_strobe, done = 0.
  - State = IDLE; wrap count = 0.
  - phase_prev = 0.
- Wrap detection:
  - phase_prev <= phase_in every cycle, in all states.
  - wrap = (phase_in < phase_prev), unsigned 8-bit compare.
  - An accumulator factor of 0 still advances by 1, so no special case is needed.
- States: IDLE, DWELL, PAUSED.
- IDLE:
  - start=1 and abort=0 → next edge: latch mode_cont, dir_up, start_factor, stop_factor and dwell_eff = max(dwell_cycles, 1).
  - Same edge: frequency_factor <= start_factor, count <= 0, busy <= 1, state DWELL.
  - No step_strobe is issued on the initial load.
- DWELL:
  - Each wrap increments count.
  - On the wrap where count == dwell_eff-1 (final wrap), one of three cases applies:
    - Factor == stop_lat, or the next step would pass stop_lat (start beyond stop in the sweep direction), and single-shot: done pulse, busy <= 0, frequency_factor <= IDLE_FACTOR, state IDLE.
    - Same end condition, continuous: frequency_factor <= start_lat, step_strobe pulse, count <= 0.
    - Otherwise: frequency_factor <= factor+1 (dir_up) or factor-1, step_strobe pulse, count <= 0.
  - Factor arithmetic is 4-bit.
  - The end test precedes every step, so 15→0 and 0→15 never wrap.
  - pause=1 with no final-wrap event in the same cycle → PAUSED.
  - If the final wrap and pause coincide, the step/finish is taken first and the next cycle enters PAUSED.
- PAUSED:
  - Factor held; wraps ignored; count held.
  - pause=0 → DWELL.
- abort:
  - Highest priority in DWELL/PAUSED: next edge frequency_factor <= IDLE_FACTOR, busy <= 0, done pulse, state IDLE.
  - abort in IDLE is ignored.
  - abort wins over a simultaneous start in IDLE: start is dropped and no done pulse is issued.
- start while busy is ignored.
- Input changes mid-sweep have no effect, because configuration is latched.
- Asynchronous reset mid-sweep returns all outputs to reset values immediately.
- Latency: factor change is registered, visible one cycle after the wrap that triggers it.
- step_strobe and done are never high for more than one cycle and never high together.

Optional Feature:
- Macro: SWEEP_PINGPONG_EN.
- Defined:
  - In continuous mode, reaching an endpoint reverses the direction instead of reloading start_lat.
  - The factor steps back toward start_lat. On reaching start_lat it reverses again.
  - Each endpoint factor dwells once per pass; step_strobe pulses on every change.
- Undefined: continuous mode reloads start_lat as described under Behaviour. The dir_up latch never changes during a sweep.

Test Plan:
- Single-shot up sweep:
  - Stimulus: start_factor=2, stop_factor=5, dwell_cycles=3, phase_in from a real accumulator model.
  - Response: factor sequence 2,3,4,5 with three wraps at each step. step_strobe pulses 3 times. Then done pulses once, busy=0 and factor=IDLE_FACTOR.
- Down sweep with dwell_cycles=0: start=3, stop=1, dir_up=0.
  - Response: factors 3,2,1, one wrap each, then done.
- Boundary cases:
  - start=stop=15, dir_up=1: dwells at 15, then done; no step_strobe and no wrap to 0.
  - start=4, stop=2, dir_up=1: one dwell at 4, then done.
- Continuous mode, start=1, stop=3, dwell=1, nine wraps:
  - Without the macro: sequence 1,2,3,1,2,3,1,2,3.
  - With SWEEP_PINGPONG_EN: sequence 1,2,3,2,1,2,3,2,1.
- Pause and abort:
  - Pause for 20 wraps mid-dwell: the count does not advance and the step occurs only after release.
  - Abort on the same cycle as a final wrap: factor=IDLE_FACTOR, done=1 and step_strobe=0.
  - Start while busy is ignored.
- rst_n asserted mid-sweep: outputs return to reset values asynchronously. The first start after release behaves normally.
